// File: rtl/am_seq_pkg.sv
// am_seq_pkg
// Shared definitions for the AM29xx machine-cycle phase sequencer:
// FSM state encoding, phase index width and completed-cycle counter width.
package am_seq_pkg;

   localparam int PHASE_W = 3;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } seq_state_e;

endpackage

// File: rtl/am_phase_ctr.sv
// am_phase_ctr
// Small loadable up-counter used to hold the phase index driven to the
// decoder select lines. Priority: rst/clr, load, increment, hold.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset (clears q)
//   clr   in  synchronous clear to zero
//   load  in  load q from d
//   d     in  load value
//   inc   in  increment q by one (wraps at 2**PHASE_W)
//   q     out current count
module am_phase_ctr
   import am_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               load,
   input  logic [PHASE_W-1:0] d,
   input  logic               inc,
   output logic [PHASE_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (inc) begin
         q <= q + PHASE_W'(1);
      end
   end

endmodule

// File: rtl/am_phase_sequencer.sv
// am_phase_sequencer
// Machine-cycle phase sequencer. Drives the select/enable inputs of a
// 3-to-8 decoder so its active-low outputs form one-hot phase strobes.
// Supports free-running, single-step and ready-stretched cycles; a halt
// (run dropped) always lets the current cycle finish through LAST_PHASE.
//
// state | meaning
// IDLE  | no cycle in progress, decoder disabled, waiting for run/step
// RUN   | stepping through phases 0..LAST_PHASE
// WAIT  | stalled at WAIT_PHASE until ready goes high
//
// Ports:
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset, highest priority
//   run        in  level request for back-to-back cycles
//   step       in  single-cycle request, sampled only in IDLE
//   ready      in  memory/IO ready, sampled only at WAIT_PHASE
//   sel        out phase index {c,b,a} to the decoder
//   g1         out decoder enable, active high
//   g2a_       out decoder enable, active low
//   g2b_       out decoder enable, active low
//   busy       out a cycle is in progress
//   cycle_end  out high in the clock where LAST_PHASE is left
//   cycle_cnt  out completed-cycle count, wraps
module am_phase_sequencer
   import am_seq_pkg::*;
#(
   parameter int LAST_PHASE = 7,
   parameter int WAIT_PHASE = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               step,
   input  logic               ready,
   output logic [PHASE_W-1:0] sel,
   output logic               g1,
   output logic               g2a_,
   output logic               g2b_,
   output logic               busy,
   output logic               cycle_end,
   output logic [CNT_W-1:0]   cycle_cnt
);

   localparam logic [PHASE_W-1:0] LAST_P = PHASE_W'(LAST_PHASE);
   localparam logic [PHASE_W-1:0] WAIT_P = PHASE_W'(WAIT_PHASE);

   seq_state_e state;
   logic       single;
   logic       stall;
   logic       at_last;
   logic       end_adv;
   logic       ctr_clr;
   logic       ctr_inc;

   am_phase_ctr u_phase_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (ctr_clr),
      .load (1'b0),
      .d    ('0),
      .inc  (ctr_inc),
      .q    (sel)
   );

   // A stall covers both entering WAIT from RUN and remaining in WAIT; in
   // WAIT, sel always equals WAIT_PHASE so the same compare applies.
   always_comb begin
      stall   = (state != IDLE) && (sel == WAIT_P) && !ready;
      at_last = (sel == LAST_P);
      end_adv = (state != IDLE) && at_last && !stall;
      ctr_clr = 1'b0;
      ctr_inc = 1'b0;
      case (state)
         IDLE: ctr_clr = run | step;
         default: begin
            if (!stall) begin
               if (at_last) ctr_clr = 1'b1;
               else         ctr_inc = 1'b1;
            end
         end
      endcase
      // Reset wins, so a cycle cut short by rst never shows a completion.
      cycle_end = end_adv && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         single    <= 1'b0;
         g1        <= 1'b0;
         g2a_      <= 1'b1;
         g2b_      <= 1'b1;
         busy      <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (run || step) begin
                  state  <= RUN;
                  single <= !run;
                  g1     <= 1'b1;
                  g2a_   <= 1'b0;
                  g2b_   <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            RUN, WAIT: begin
               if (stall) begin
                  state <= WAIT;
               end else if (!at_last) begin
                  state <= RUN;
               end else begin
                  cycle_cnt <= cycle_cnt + CNT_W'(1);
                  // A single-step cycle never chains, even if run rose meanwhile.
                  if (run && !single) begin
                     state <= RUN;
                  end else begin
                     state <= IDLE;
                     g1    <= 1'b0;
                     g2a_  <= 1'b1;
                     g2b_  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               g1    <= 1'b0;
               g2a_  <= 1'b1;
               g2b_  <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
